// File: rtl/struct_union_pkg.sv
// Shared types for struct_union_alu: opcodes, signedness flag, signed/unsigned
// data views and the packed instruction word.
package struct_union_pkg;

  typedef enum logic [2:0] {
    add = 3'd0,
    sub = 3'd1,
    mul = 3'd2,
    div = 3'd3,
    sl  = 3'd4,
    sr  = 3'd5
  } opcode_t;

  typedef enum logic {
    sign   = 1'b0,
    unsign = 1'b1
  } operand_type_t;

  typedef union packed {
    logic [31:0]      u_data;
    bit signed [31:0] s_data;
  } data_t;

  typedef union packed {
    logic [63:0]      u_data;
    bit signed [63:0] s_data;
  } l_data_t;

  typedef struct packed {
    opcode_t       opr;
    operand_type_t opr_type;
    data_t         opr_a;
    data_t         opr_b;
  } instr_t;

endpackage

// File: rtl/struct_union_div.sv
// Combinational 32-bit divider, signed or unsigned, truncating toward zero.
// The quotient is returned already extended to 64 bits so -2^31 / -1 = +2^31.
module struct_union_div (
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] quotient,
  output logic        div_zero
);

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic        neg;

  // Divide magnitudes; |-2^31| still fits as an unsigned 32-bit value.
  always_comb begin
    a_mag    = (is_signed && a[31]) ? (~a + 32'd1) : a;
    b_mag    = (is_signed && b[31]) ? (~b + 32'd1) : b;
    neg      = is_signed && (a[31] ^ b[31]);
    div_zero = (b == 32'd0);
    q_mag    = div_zero ? 32'd0 : (a_mag / b_mag);
    quotient = neg ? (~{32'd0, q_mag} + 64'd1) : {32'd0, q_mag};
  end

endmodule

// File: rtl/struct_union_alu.sv
// Registered 32-bit ALU, 64-bit result one cycle after iw is sampled.
// Define STRUCT_UNION_ALU_DIV_EN to build the divider; otherwise div yields 0.
module struct_union_alu
  import struct_union_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  instr_t  iw,
  output l_data_t result,
  output logic    div_zero
);

  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] res_d;
  logic [63:0] quotient;
  logic        dz_div;
  logic        dz_d;
  logic [5:0]  sh;

  always_comb begin
    if (iw.opr_type == unsign) begin
      a_ext = {32'd0, iw.opr_a.u_data};
      b_ext = {32'd0, iw.opr_b.u_data};
    end else begin
      a_ext = {{32{iw.opr_a.u_data[31]}}, iw.opr_a.u_data};
      b_ext = {{32{iw.opr_b.u_data[31]}}, iw.opr_b.u_data};
    end
    sh = iw.opr_b.u_data[5:0];
  end

`ifdef STRUCT_UNION_ALU_DIV_EN
  struct_union_div u_div (
    .is_signed (iw.opr_type == sign),
    .a         (iw.opr_a.u_data),
    .b         (iw.opr_b.u_data),
    .quotient  (quotient),
    .div_zero  (dz_div)
  );
`else
  assign quotient = 64'd0;
  assign dz_div   = 1'b0;
`endif

  // Unknown or reserved opcodes fall through to the zero default.
  always_comb begin
    res_d = 64'd0;
    dz_d  = 1'b0;
    case (iw.opr)
      add: res_d = a_ext + b_ext;
      sub: res_d = a_ext - b_ext;
      mul: res_d = a_ext * b_ext;
      div: begin
        res_d = quotient;
        dz_d  = dz_div;
      end
      sl:  res_d = a_ext << sh;
      sr:  res_d = (iw.opr_type == sign) ? 64'($signed(a_ext) >>> sh) : (a_ext >> sh);
      default: res_d = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result.u_data <= 64'd0;
      div_zero      <= 1'b0;
    end else begin
      result.u_data <= res_d;
      div_zero      <= dz_d;
    end
  end

endmodule

// File: tb/tb_struct_union_alu.sv
// Directed bench for struct_union_alu: longint reference model checked every
// cycle through an expected queue, plus hand-computed literal expectations.
module tb_struct_union_alu;
  import struct_union_pkg::*;

  logic    clk;
  logic    rst_n;
  instr_t  iw;
  l_data_t result;
  logic    div_zero;

  int n_tests = 0;
  int n_fail  = 0;

  logic [64:0] exp_q[$];

  logic        pend;
  logic [63:0] pend_res;
  logic        pend_dz;
  string       pend_name;

  struct_union_alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iw       (iw),
    .result   (result),
    .div_zero (div_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit integer arithmetic on extended operands.
  function automatic logic [64:0] model(input logic [2:0] op, input logic t,
                                        input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    logic [63:0] r;
    logic        dz;
    sa = t ? longint'({32'd0, a}) : longint'(int'(a));
    sb = t ? longint'({32'd0, b}) : longint'(int'(b));
    r  = 64'd0;
    dz = 1'b0;
    case (op)
      3'd0: r = 64'(sa + sb);
      3'd1: r = 64'(sa - sb);
      3'd2: r = 64'(sa * sb);
      3'd3: begin
`ifdef STRUCT_UNION_ALU_DIV_EN
        if (b == 32'd0) dz = 1'b1;
        else r = 64'(sa / sb);
`endif
      end
      3'd4: r = 64'(sa << b[5:0]);
      3'd5: r = t ? (64'(sa) >> b[5:0]) : 64'(sa >>> b[5:0]);
      default: r = 64'd0;
    endcase
    return {dz, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: push on capture edge, compare on the opposite edge
  always @(posedge clk) begin
    if (rst_n)
      exp_q.push_back(model(iw.opr, iw.opr_type, iw.opr_a.u_data, iw.opr_b.u_data));
  end

  always @(negedge clk) begin
    logic [64:0] e;
    if (!rst_n) begin
      exp_q.delete();
      chk("in_reset_result", result.u_data, 64'd0);
      chk("in_reset_dz", {63'd0, div_zero}, 64'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("model_result", result.u_data, e[63:0]);
      chk("model_dz", {63'd0, div_zero}, {63'd0, e[64]});
    end
  end

  // driver
  task automatic check_pending();
    if (pend) begin
      chk({pend_name, "_res"}, result.u_data, pend_res);
      chk({pend_name, "_dz"}, {63'd0, div_zero}, {63'd0, pend_dz});
    end
  endtask

  task automatic step(input logic [2:0] op, input logic t, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] lit, input logic lit_dz,
                      input string name);
    @(negedge clk);
    check_pending();
    iw.opr          = opcode_t'(op);
    iw.opr_type     = operand_type_t'(t);
    iw.opr_a.u_data = a;
    iw.opr_b.u_data = b;
    pend      = 1'b1;
    pend_res  = lit;
    pend_dz   = lit_dz;
    pend_name = name;
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
    pend = 1'b0;
  endtask

  initial begin
    pend  = 1'b0;
    rst_n = 1'b0;
    iw    = instr_t'({$urandom_range(7, 0), $urandom(), $urandom(), $urandom()});
    repeat (3) @(negedge clk);
    iw.opr = mul;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_release_res", result.u_data, 64'd0);
    chk("post_release_dz", {63'd0, div_zero}, 64'd0);

    // back-to-back opcode walk, signed 0x10 / 0x20
    step(3'd0, 1'b0, 32'h10, 32'h20, 64'h30, 1'b0, "walk_add");
    step(3'd1, 1'b0, 32'h10, 32'h20, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0, "walk_sub");
    step(3'd2, 1'b0, 32'h10, 32'h20, 64'h200, 1'b0, "walk_mul");
    step(3'd3, 1'b0, 32'h10, 32'h20, 64'h0, 1'b0, "walk_div");
    step(3'd4, 1'b0, 32'h10, 32'h20, 64'h0000_0010_0000_0000, 1'b0, "walk_sl");
    step(3'd5, 1'b0, 32'h10, 32'h20, 64'h0, 1'b0, "walk_sr");

    // signedness
    step(3'd0, 1'b1, 32'hFFFF_FFFF, 32'h1, 64'h1_0000_0000, 1'b0, "add_unsign");
    step(3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 64'h0, 1'b0, "add_sign");
    step(3'd2, 1'b1, 32'hFFFF_FFFF, 32'h2, 64'h1_FFFF_FFFE, 1'b0, "mul_unsign");
    step(3'd2, 1'b0, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "mul_sign");
    step(3'd1, 1'b1, 32'h0, 32'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "sub_unsign_wrap");

    // shifts, including ignored upper shift-amount bits
    step(3'd5, 1'b0, 32'h8000_0000, 32'h4, 64'hFFFF_FFFF_F800_0000, 1'b0, "sr_sign");
    step(3'd5, 1'b1, 32'h8000_0000, 32'h4, 64'h0800_0000, 1'b0, "sr_unsign");
    step(3'd4, 1'b1, 32'h1, 32'h100_003F, 64'h8000_0000_0000_0000, 1'b0, "sl_mask");
    step(3'd4, 1'b0, 32'h8000_0000, 32'h1, 64'hFFFF_FFFF_0000_0000, 1'b0, "sl_sign");

    // division corners
`ifdef STRUCT_UNION_ALU_DIV_EN
    step(3'd3, 1'b0, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, "div_neg7_2");
    step(3'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, "div_min_m1");
    step(3'd3, 1'b1, 32'hFFFF_FFFF, 32'h2, 64'h7FFF_FFFF, 1'b0, "div_unsign");
    step(3'd3, 1'b0, 32'h7, 32'h0, 64'h0, 1'b1, "div_by_zero");
`else
    step(3'd3, 1'b0, 32'hFFFF_FFF9, 32'h2, 64'h0, 1'b0, "div_off_neg7_2");
    step(3'd3, 1'b1, 32'hFFFF_FFFF, 32'h2, 64'h0, 1'b0, "div_off_unsign");
    step(3'd3, 1'b0, 32'h7, 32'h0, 64'h0, 1'b0, "div_off_zero");
`endif

    // reserved opcodes
    step(3'd6, 1'b0, 32'h5, 32'h3, 64'h0, 1'b0, "rsvd6");
    step(3'd7, 1'b1, 32'h5, 32'h3, 64'h0, 1'b0, "rsvd7");

    // mid-stream asynchronous reset
    step(3'd2, 1'b1, 32'h1234, 32'h10, 64'h12340, 1'b0, "pre_reset_mul");
    flush();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_res", result.u_data, 64'd0);
    chk("async_reset_dz", {63'd0, div_zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(3'd0, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0, "post_reset_add");
    step(3'd1, 1'b0, 32'h3, 32'h5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, "post_reset_sub");
    flush();
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
